// File: rtl/pong_match_ctrl.sv
// Match-level sequencer for the pong ball engine: serve countdown, point freeze,
// pause and winner detection, all outputs registered.
module pong_match_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 60,
    parameter int POINT_TICKS = 90
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic [3:0] p1s,
    input  logic [3:0] p2s,
    output logic [1:0] mode,
    output logic       eng_reset_n,
    output logic [7:0] countdown,
    output logic [1:0] winner,
    output logic       paused
);

    localparam logic [7:0] SERVE_CNT = 8'(SERVE_TICKS);
    localparam logic [7:0] POINT_CNT = 8'(POINT_TICKS);
    localparam logic [3:0] WIN_Q     = 4'(WIN_SCORE);

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_PLAY = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b10;
    localparam logic [1:0] MODE_OVER = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SERVE,
        ST_PLAY,
        ST_POINT,
        ST_PAUSE,
        ST_OVER
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic       ern_q, ern_d;
    logic [7:0] cd_q, cd_d;
    logic [1:0] win_q, win_d;
    logic       paused_q, paused_d;
    logic [3:0] p1_q, p1_d;
    logic [3:0] p2_q, p2_d;
    logic       start_q, pause_q;

    logic start_e, pause_e, score_chg, p1_win, p2_win;

    assign start_e   = btn_start & ~start_q;
    assign pause_e   = btn_pause & ~pause_q;
    assign score_chg = (p1s != p1_q) || (p2s != p2_q);
    assign p1_win    = (p1s >= WIN_Q);
    assign p2_win    = (p2s >= WIN_Q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_IDLE;
            ern_q    <= 1'b0;
            cd_q     <= 8'd0;
            win_q    <= 2'b00;
            paused_q <= 1'b0;
            p1_q     <= 4'd0;
            p2_q     <= 4'd0;
            // Held buttons must not look like a fresh press after reset.
            start_q  <= 1'b1;
            pause_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            ern_q    <= ern_d;
            cd_q     <= cd_d;
            win_q    <= win_d;
            paused_q <= paused_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            start_q  <= btn_start;
            pause_q  <= btn_pause;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        ern_d    = ern_q;
        cd_d     = cd_q;
        win_d    = win_q;
        paused_d = paused_q;
        // Shadows follow the engine; only a change seen in PLAY is a point.
        p1_d     = p1s;
        p2_d     = p2s;

        unique case (state_q)
            ST_IDLE: begin
                mode_d = MODE_IDLE;
                ern_d  = 1'b0;
                cd_d   = 8'd0;
                if (start_e) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                // Release engine reset only on a tick so the engine sees it on a ball-clock edge.
                if (tick) begin
                    ern_d   = 1'b1;
                    p1_d    = 4'd0;
                    p2_d    = 4'd0;
                    win_d   = 2'b00;
                    cd_d    = SERVE_CNT;
                    mode_d  = MODE_HOLD;
                    state_d = ST_SERVE;
                end else begin
                    mode_d = MODE_IDLE;
                    ern_d  = 1'b0;
                end
            end
            ST_SERVE: begin
                if (tick) begin
                    if (cd_q <= 8'd1) begin
                        cd_d    = 8'd0;
                        mode_d  = MODE_PLAY;
                        state_d = ST_PLAY;
                    end else begin
                        cd_d = cd_q - 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (score_chg) begin
                    if (p1_win || p2_win) begin
                        win_d   = {p2_win, p1_win};
                        mode_d  = MODE_OVER;
                        state_d = ST_OVER;
                    end else begin
                        cd_d    = POINT_CNT;
                        mode_d  = MODE_HOLD;
                        state_d = ST_POINT;
                    end
                end else if (pause_e) begin
                    mode_d   = MODE_HOLD;
                    paused_d = 1'b1;
                    state_d  = ST_PAUSE;
                end
            end
            ST_POINT: begin
                if (tick) begin
                    if (cd_q <= 8'd1) begin
                        cd_d    = SERVE_CNT;
                        state_d = ST_SERVE;
                    end else begin
                        cd_d = cd_q - 8'd1;
                    end
                end
            end
            ST_PAUSE: begin
                if (start_e) begin
                    mode_d   = MODE_IDLE;
                    ern_d    = 1'b0;
                    paused_d = 1'b0;
                    state_d  = ST_CLEAR;
                end else if (pause_e) begin
                    mode_d   = MODE_PLAY;
                    paused_d = 1'b0;
                    state_d  = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (start_e) begin
                    mode_d  = MODE_IDLE;
                    ern_d   = 1'b0;
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mode        = mode_q;
    assign eng_reset_n = ern_q;
    assign countdown   = cd_q;
    assign winner      = win_q;
    assign paused      = paused_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: fixed vector table plus random stimulus against a
// behavioural match model.
module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       reset, tick, btn_start, btn_pause;
    logic [3:0] p1s, p2s;
    logic [1:0] mode;
    logic       eng_reset_n;
    logic [7:0] countdown;
    logic [1:0] winner;
    logic       paused;

    localparam int WIN = 7;
    localparam int SRV = 60;
    localparam int PNT = 90;

    pong_match_ctrl #(.WIN_SCORE(WIN), .SERVE_TICKS(SRV), .POINT_TICKS(PNT)) dut (
        .clk(clk), .reset(reset), .tick(tick), .btn_start(btn_start), .btn_pause(btn_pause),
        .p1s(p1s), .p2s(p2s), .mode(mode), .eng_reset_n(eng_reset_n),
        .countdown(countdown), .winner(winner), .paused(paused)
    );

    always #5 clk = ~clk;

    logic [13:0] dut_out;
    assign dut_out = {mode, eng_reset_n, countdown, winner, paused};

    int total = 0;
    int bad   = 0;

    // Behavioural match model: phase names are the match phases, counts are plain ints.
    localparam int PH_IDLE = 0, PH_CLEAR = 1, PH_SERVE = 2, PH_PLAY = 3,
                   PH_POINT = 4, PH_PAUSE = 5, PH_OVER = 6;
    int   phase = PH_IDLE;
    int   m_cd = 0, m_mode = 0, m_win = 0;
    bit   m_ern = 0, m_paused = 0;
    int   seen1 = 0, seen2 = 0;
    bit   last_s = 1, last_p = 1;

    function automatic logic [13:0] pk(int m, int e, int c, int w, int p);
        return {2'(m), 1'(e), 8'(c), 2'(w), 1'(p)};
    endfunction

    task automatic model_step(input bit r, t, s, p, input int a, b);
        bit press_s, press_p, zero_shadow;
        if (r) begin
            phase = PH_IDLE; m_cd = 0; m_mode = 0; m_win = 0; m_ern = 0; m_paused = 0;
            seen1 = 0; seen2 = 0; last_s = 1; last_p = 1;
            return;
        end
        press_s = s && !last_s;
        press_p = p && !last_p;
        last_s = s;
        last_p = p;
        zero_shadow = 0;
        case (phase)
            PH_IDLE: begin
                m_mode = 0; m_ern = 0; m_cd = 0;
                if (press_s) phase = PH_CLEAR;
            end
            PH_CLEAR: begin
                if (t) begin
                    m_ern = 1; m_win = 0; m_cd = SRV; m_mode = 2; phase = PH_SERVE;
                    zero_shadow = 1;
                end else begin
                    m_mode = 0; m_ern = 0;
                end
            end
            PH_SERVE: if (t) begin
                m_cd = m_cd - 1;
                if (m_cd == 0) begin m_mode = 1; phase = PH_PLAY; end
            end
            PH_PLAY: begin
                if (a != seen1 || b != seen2) begin
                    if (a >= WIN || b >= WIN) begin
                        m_win = (a >= WIN ? 1 : 0) + (b >= WIN ? 2 : 0);
                        m_mode = 3; phase = PH_OVER;
                    end else begin
                        m_cd = PNT; m_mode = 2; phase = PH_POINT;
                    end
                end else if (press_p) begin
                    m_mode = 2; m_paused = 1; phase = PH_PAUSE;
                end
            end
            PH_POINT: if (t) begin
                m_cd = m_cd - 1;
                if (m_cd == 0) begin m_cd = SRV; phase = PH_SERVE; end
            end
            PH_PAUSE: begin
                if (press_s) begin
                    m_mode = 0; m_ern = 0; m_paused = 0; phase = PH_CLEAR;
                end else if (press_p) begin
                    m_mode = 1; m_paused = 0; phase = PH_PLAY;
                end
            end
            PH_OVER: if (press_s) begin
                m_mode = 0; m_ern = 0; phase = PH_CLEAR;
            end
            default: phase = PH_IDLE;
        endcase
        if (zero_shadow) begin seen1 = 0; seen2 = 0; end
        else begin seen1 = a; seen2 = b; end
    endtask

    task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got mode=%0d ern=%0d cd=%0d win=%0d paused=%0d, expected mode=%0d ern=%0d cd=%0d win=%0d paused=%0d",
                     name, $time, act[13:12], act[11], act[10:3], act[2:1], act[0],
                     exp[13:12], exp[11], exp[10:3], exp[2:1], exp[0]);
        end
    endtask

    task automatic cyc(input bit r, t, s, p, input logic [3:0] a, b);
        reset = r; tick = t; btn_start = s; btn_pause = p; p1s = a; p2s = b;
        model_step(r, t, s, p, int'(a), int'(b));
        @(posedge clk);
        @(negedge clk);
        chk("model", dut_out, pk(m_mode, m_ern, m_cd, m_win, m_paused));
    endtask

    typedef struct {
        int          n;
        bit          r, t, s, p;
        logic [3:0]  a, b;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input bit r, t, s, p, input int a, b,
                       input int m, e, c, w, pz);
        vec_t v;
        v.n = n; v.r = r; v.t = t; v.s = s; v.p = p;
        v.a = 4'(a); v.b = 4'(b);
        v.exp = pk(m, e, c, w, pz);
        tbl.push_back(v);
    endtask

    initial begin
        logic [3:0] ra, rb;
        bit rs, rp;
        reset = 1'b1; tick = 1'b0; btn_start = 1'b0; btn_pause = 1'b0; p1s = '0; p2s = '0;

        //   n   r t s p  p1 p2   mode ern cd win pz
        add(2,   1,0,1,0, 0, 0,   0,0, 0,0,0);  // start held through reset
        add(3,   0,0,1,0, 0, 0,   0,0, 0,0,0);
        add(1,   0,0,0,0, 0, 0,   0,0, 0,0,0);
        add(1,   0,0,1,0, 0, 0,   0,0, 0,0,0);  // press: CLEAR
        add(2,   0,0,0,0, 0, 0,   0,0, 0,0,0);
        add(1,   0,1,0,0, 0, 0,   2,1,60,0,0);  // CLEAR tick -> SERVE
        add(59,  0,1,0,0, 0, 0,   2,1, 1,0,0);
        add(1,   0,1,0,0, 0, 0,   1,1, 0,0,0);  // PLAY
        add(3,   0,0,0,0, 0, 0,   1,1, 0,0,0);
        add(1,   0,0,0,0, 1, 0,   2,1,90,0,0);  // point
        add(89,  0,1,0,0, 1, 0,   2,1, 1,0,0);
        add(1,   0,1,0,0, 1, 0,   2,1,60,0,0);  // reload serve
        add(60,  0,1,0,0, 1, 0,   1,1, 0,0,0);
        add(1,   0,0,0,1, 1, 0,   2,1, 0,0,1);  // pause
        add(2,   0,1,0,0, 1, 0,   2,1, 0,0,1);
        add(1,   0,0,0,1, 1, 0,   1,1, 0,0,0);  // resume
        add(1,   0,0,0,0, 1, 0,   1,1, 0,0,0);
        add(1,   0,0,0,1, 2, 0,   2,1,90,0,0);  // pause + point: point wins
        add(90,  0,1,0,0, 6, 6,   2,1,60,0,0);
        add(60,  0,1,0,0, 6, 6,   1,1, 0,0,0);
        add(1,   0,0,0,0, 7, 7,   3,1, 0,3,0);  // draw
        add(5,   0,1,0,0, 7, 7,   3,1, 0,3,0);
        add(1,   0,0,1,0, 7, 7,   0,0, 0,3,0);  // restart, winner held
        add(1,   0,1,0,0, 0, 0,   2,1,60,0,0);
        add(60,  0,1,0,0, 0, 0,   1,1, 0,0,0);
        add(1,   0,0,0,0, 0, 6,   2,1,90,0,0);
        add(90,  0,1,0,0, 0, 6,   2,1,60,0,0);
        add(60,  0,1,0,0, 0, 6,   1,1, 0,0,0);
        add(1,   0,0,0,0, 0, 7,   3,1, 0,2,0);  // P2 wins
        add(3,   0,1,0,0, 0, 7,   3,1, 0,2,0);
        add(1,   0,0,1,0, 0, 7,   0,0, 0,2,0);
        add(1,   0,1,0,0, 0, 0,   2,1,60,0,0);
        add(1,   0,1,1,0, 0, 0,   2,1,59,0,0);  // start ignored in SERVE
        add(4,   0,1,0,0, 0, 0,   2,1,55,0,0);
        add(1,   1,0,0,0, 0, 0,   0,0, 0,0,0);  // reset mid-serve
        add(1,   0,0,0,0, 0, 0,   0,0, 0,0,0);
        add(1,   0,0,1,0, 0, 0,   0,0, 0,0,0);
        add(1,   0,1,0,0, 0, 0,   2,1,60,0,0);
        add(60,  0,1,0,0,15, 0,   1,1, 0,0,0);
        add(1,   0,0,0,0, 0, 0,   2,1,90,0,0);  // 15->0 wrap is a point

        @(negedge clk);
        foreach (tbl[k]) begin
            for (int i = 0; i < tbl[k].n; i++)
                cyc(tbl[k].r, tbl[k].t, tbl[k].s, tbl[k].p, tbl[k].a, tbl[k].b);
            chk($sformatf("row%0d", k), dut_out, tbl[k].exp);
        end

        ra = '0; rb = '0; rs = 1'b0; rp = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            int k;
            if ($urandom_range(0, 11) == 0) rs = ~rs;
            if ($urandom_range(0, 8) == 0)  rp = ~rp;
            k = int'($urandom_range(0, 39));
            if (!m_ern) begin ra = '0; rb = '0; end
            else if (k == 0) ra = ra + 4'd1;
            else if (k == 1) rb = rb + 4'd1;
            else if (k == 2) begin ra = ra + 4'd1; rb = rb + 4'd1; end
            else if (k == 3) ra = 4'($urandom);
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, rs, rp, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match-level sequencer for the ball/paddle engine. Drives the engine's 2-bit mode input, where only 2'b01 lets the ball move, and its active-low engine reset.
- Watches the two player score outputs to detect points, pauses play between points and declares the winner at a target score.
- Sits between the start/pause push-buttons and the ball engine; its countdown and winner outputs feed the VGA overlay.

Parameters:
- WIN_SCORE, 7, score either player must reach to win (1..15)
- SERVE_TICKS, 60, frame ticks of countdown before each serve (1..255)
- POINT_TICKS, 90, frame ticks of freeze after a point (1..255)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-clk frame-rate enable pulse (same rate as the engine's ball clock)
- btn_start  in  1  start/restart push-button, level, already synchronised
- btn_pause  in  1  pause push-button, level, already synchronised
- p1s  in  4  player 1 score from ball engine
- p2s  in  4  player 2 score from ball engine
- mode  out  2  engine mode: 00 idle, 01 play, 10 hold, 11 over
- eng_reset_n  out  1  active-low engine reset (clears ball position and scores)
- countdown  out  8  remaining serve/point ticks, 0 outside SERVE/POINT
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw
- paused  out  1  high in PAUSE state

Behaviour:
- Reset values: state=IDLE, mode=00, eng_reset_n=0, countdown=0, winner=00, paused=0. Score shadows p1q and p2q clear to 0.
- Button edges: btn_start and btn_pause are rising-edge detected internally (one-clk pulses start_e and pause_e). Edge registers reset to 1, so a button held through reset does not fire.
- All outputs are registered, so any state change appears one clk later.
- IDLE: mode=00, eng_reset_n=0. On start_e go to CLEAR.
- CLEAR: eng_reset_n=0, mode=00. Hold until the first tick, so the engine sees its reset on an active ball-clock edge. On that tick: eng_reset_n returns to 1, p1q=p2q=0, winner=00, countdown=SERVE_TICKS, go to SERVE.
- SERVE: mode=10. Each tick decrements countdown. The tick on which countdown goes 1->0 sets mode=01 and moves to PLAY.
- PLAY: mode=01. Point detection compares p1s against p1q and p2s against p2q every clk.
  - On a mismatch, update the shadows and evaluate the win condition.
  - If p1s>=WIN_SCORE or p2s>=WIN_SCORE, go to OVER.
  - Otherwise set countdown=POINT_TICKS, mode=10 and go to POINT.
  - Win is judged on the new values. Both reaching WIN in the same clk gives winner=11. Otherwise the player at or above WIN wins (01 or 10).
  - pause_e in PLAY with no score change goes to PAUSE. A simultaneous score change takes priority and the pause is dropped.
- POINT: mode=10. Each tick decrements countdown. At 0, reload countdown=SERVE_TICKS and go to SERVE.
- PAUSE: mode=10, paused=1. pause_e returns to PLAY with mode=01. start_e goes to CLEAR, which restarts the match.
- OVER: mode=11, winner held. start_e goes to CLEAR; winner clears on CLEAR's tick.
- start_e in SERVE or POINT is ignored. Restart is only possible from IDLE, PAUSE or OVER.
- Score inputs only matter in PLAY. In other states the shadows track p1s/p2s every clk, so engine score changes outside PLAY never produce a point.
- Score wrap: a value decreasing (15->0 wrap) is still a mismatch and counts as a point. With WIN_SCORE<=15 a win is reached before the wrap.
- tick and a button edge in the same clk: the button transition wins, except in CLEAR, where only tick matters.
- reset asserted mid-match returns to IDLE within one clk. eng_reset_n=0 holds the engine in reset.

Test Plan:
- Reset, then start_e, then 1 tick: eng_reset_n low until that tick then 1; mode=10 and countdown=60; after 60 more ticks mode=01.
- In PLAY, change p1s 0->1: one clk later mode=10, countdown=90, state POINT; after 90 ticks countdown reloads to 60; after 60 more ticks mode=01.
- Drive p2s 6->7 with WIN_SCORE=7: mode=11, winner=10; extra ticks change nothing; start_e leads through CLEAR to winner=00 and SERVE.
- In PLAY with p1s=6 and p2s=6, change both to 7 in the same clk: winner=11, mode=11.
- In PLAY, pulse pause_e: paused=1, mode=10; second pause_e gives mode=01. Pause in the same clk as a p1s change: goes to POINT, paused stays 0.
- Hold btn_start high through reset release: no start_e, state stays IDLE; assert reset during SERVE: next clk mode=00, eng_reset_n=0, countdown=0.
